// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read path: FSM state encoding,
// captured descriptor layout, MRd header fields and the max-read-request decode.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HDR1 = 2'd2,
        ST_HDR2 = 2'd3
    } rd_state_e;

    // Descriptor fields are held at a fixed maximum width. The top
    // zero-extends its parameterised inputs into them and slices them back out.
    typedef struct packed {
        logic [63:0] haddr;
        logic [31:0] len;
        logic [31:0] maddr;
        logic [7:0]  iface;
        logic [7:0]  mem;
    } rd_desc_t;

    localparam logic [1:0] FMT_MRD_3DW = 2'b00;
    localparam logic [1:0] FMT_MRD_4DW = 2'b01;
    localparam logic [4:0] TYPE_MRD    = 5'b00000;

    // 128 << cfg, clamped to the hard cap. The result fits 13 bits (max 4096).
    function automatic logic [12:0] mrrs_bytes(input logic [2:0] cfg, input int max_bytes);
        int b;
        b = 128 << cfg;
        if (b > max_bytes) b = max_bytes;
        return b[12:0];
    endfunction

endpackage

// File: rtl/pcie_rd_chunker.sv
// Combinational chunk sizing for one MRd TLP:
// chunk = min(remaining, effective MRRS, bytes left to the next 4KB boundary).
module pcie_rd_chunker #(
    parameter int LEN_W = 32
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [11:0]      haddr_lo,
    input  logic [12:0]      mrrs_bytes,
    output logic [12:0]      chunk,
    output logic [10:0]      len_dw
);

    logic [12:0] rem_sat;
    logic [12:0] bnd;
    logic [12:0] c;

    // Saturate the remaining length to 4096 so every compare is 13 bits wide.
    always_comb begin
        rem_sat = (remaining > LEN_W'(4096)) ? 13'd4096 : remaining[12:0];
        bnd     = 13'd4096 - {1'b0, haddr_lo};
        c       = rem_sat;
        if (mrrs_bytes < c) c = mrrs_bytes;
        if (bnd < c)        c = bnd;
        chunk  = c;
        len_dw = c[12:2];
    end

endmodule

// File: rtl/pcie_tx_rd_split.sv
// PCIe MRd TLP generator. It takes one DW-aligned read descriptor and splits
// it into MRd TLPs bounded by MRRS and 4KB host boundaries. It tags each TLP
// and records the TLP in the outstanding-request table.
// Optional: define PCIE_RD_STATS_EN to add the stat_tlp_cnt and stat_stall_cnt outputs.
module pcie_tx_rd_split
    import dma_pkg::*;
#(
    parameter int TAG_W        = 5,
    parameter int LEN_W        = 16,
    parameter int MEM_ADDR_W   = 19,
    parameter int IFACE_W      = 2,
    parameter int MEM_SEL_W    = 4,
    parameter int MAX_RD_BYTES = 512
) (
    input  logic                  pcie_clk,
    input  logic                  rst_n,
    input  logic [15:0]           pcie_id,
    input  logic [2:0]            cfg_mrrs,
    input  logic                  rd_desc_v,
    output logic                  rd_desc_ready,
    input  logic [63:0]           rd_desc_haddr,
    input  logic [LEN_W-1:0]      rd_desc_len,
    input  logic [IFACE_W-1:0]    rd_desc_iface,
    input  logic [MEM_SEL_W-1:0]  rd_desc_mem,
    input  logic [MEM_ADDR_W-1:0] rd_desc_maddr,
    input  logic                  tag_v,
    input  logic [TAG_W-1:0]      tag,
    output logic                  tag_take,
    output logic                  pcie_req_v,
    input  logic                  pcie_req_grant,
    input  logic                  pcie_req_stall,
    output logic                  pcie_req_done,
    output logic [63:0]           trn_td,
    output logic [7:0]            trn_trem_n,
    output logic                  trn_tsof_n,
    output logic                  trn_teof_n,
    output logic                  trn_tsrc_rdy_n,
    output logic                  ort_req_v,
    output logic [TAG_W-1:0]      ort_req_tag,
    output logic [IFACE_W-1:0]    ort_req_iface,
    output logic [MEM_SEL_W-1:0]  ort_req_mem,
    output logic [MEM_ADDR_W-1:0] ort_req_addr,
    output logic [10:0]           ort_req_len
`ifdef PCIE_RD_STATS_EN
    ,
    output logic [31:0]           stat_tlp_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);

    rd_state_e             state_q, state_d;
    rd_desc_t              desc_q, desc_d;
    logic [12:0]           chunk_q, chunk_d, calc_chunk;
    logic [10:0]           len_dw_q, len_dw_d, calc_len_dw;
    logic [63:0]           hold_td_q, hold_td_d;
    logic                  ort_v_q, ort_v_d;
    logic [TAG_W-1:0]      ort_tag_q, ort_tag_d;
    logic [IFACE_W-1:0]    ort_iface_q, ort_iface_d;
    logic [MEM_SEL_W-1:0]  ort_mem_q, ort_mem_d;
    logic [MEM_ADDR_W-1:0] ort_addr_q, ort_addr_d;
    logic [10:0]           ort_len_q, ort_len_d;

    logic [12:0] mrrs_eff;
    logic        go;
    logic        is_4dw;
    logic [31:0] dw0, dw1;
    logic [63:0] sof_td, eof_td;
    logic [7:0]  eof_trem_n;
    logic [31:0] rem_next;

    assign mrrs_eff = mrrs_bytes(cfg_mrrs, MAX_RD_BYTES);

    pcie_rd_chunker #(.LEN_W(32)) u_chunker (
        .remaining  (desc_q.len),
        .haddr_lo   (desc_q.haddr[11:0]),
        .mrrs_bytes (mrrs_eff),
        .chunk      (calc_chunk),
        .len_dw     (calc_len_dw)
    );

    // Header beats for the current chunk. A length of 1024 DW encodes as 0 in the header.
    always_comb begin
        go     = pcie_req_grant & ~pcie_req_stall;
        is_4dw = |desc_q.haddr[63:32];
        dw0    = {1'b0, (is_4dw ? FMT_MRD_4DW : FMT_MRD_3DW), TYPE_MRD,
                  1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len_dw_q[9:0]};
        dw1    = {pcie_id, 8'(tag), ((len_dw_q == 11'd1) ? 4'h0 : 4'hF), 4'hF};
        sof_td = {dw0, dw1};
        if (is_4dw) begin
            eof_td     = {desc_q.haddr[63:32], desc_q.haddr[31:2], 2'b00};
            eof_trem_n = 8'h00;
        end else begin
            eof_td     = {desc_q.haddr[31:2], 2'b00, 32'h0};
            eof_trem_n = 8'h0f;
        end
        rem_next = desc_q.len - 32'(chunk_q);
    end

    // Next-state logic and the TRN, handshake and ORT outputs.
    always_comb begin
        state_d     = state_q;
        desc_d      = desc_q;
        chunk_d     = chunk_q;
        len_dw_d    = len_dw_q;
        hold_td_d   = hold_td_q;
        ort_v_d     = 1'b0;
        ort_tag_d   = ort_tag_q;
        ort_iface_d = ort_iface_q;
        ort_mem_d   = ort_mem_q;
        ort_addr_d  = ort_addr_q;
        ort_len_d   = ort_len_q;

        rd_desc_ready  = 1'b0;
        pcie_req_v     = 1'b0;
        tag_take       = 1'b0;
        pcie_req_done  = 1'b0;
        trn_td         = 64'h0;
        trn_trem_n     = 8'hff;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;

        case (state_q)
            ST_IDLE: begin
                rd_desc_ready = 1'b1;
                if (rd_desc_v) begin
                    desc_d.haddr = rd_desc_haddr;
                    desc_d.len   = 32'(rd_desc_len);
                    desc_d.maddr = 32'(rd_desc_maddr);
                    desc_d.iface = 8'(rd_desc_iface);
                    desc_d.mem   = 8'(rd_desc_mem);
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                chunk_d  = calc_chunk;
                len_dw_d = calc_len_dw;
                state_d  = ST_HDR1;
            end
            ST_HDR1: begin
                pcie_req_v = tag_v;
                if (tag_v && go) begin
                    tag_take       = 1'b1;
                    trn_td         = sof_td;
                    trn_trem_n     = 8'h00;
                    trn_tsof_n     = 1'b0;
                    trn_tsrc_rdy_n = 1'b0;
                    hold_td_d      = sof_td;
                    ort_v_d        = 1'b1;
                    ort_tag_d      = tag;
                    ort_iface_d    = desc_q.iface[IFACE_W-1:0];
                    ort_mem_d      = desc_q.mem[MEM_SEL_W-1:0];
                    ort_addr_d     = desc_q.maddr[MEM_ADDR_W-1:0];
                    ort_len_d      = len_dw_q;
                    state_d        = ST_HDR2;
                end
            end
            ST_HDR2: begin
                pcie_req_v = 1'b1;
                if (go) begin
                    pcie_req_done  = 1'b1;
                    trn_td         = eof_td;
                    trn_trem_n     = eof_trem_n;
                    trn_teof_n     = 1'b0;
                    trn_tsrc_rdy_n = 1'b0;
                    desc_d.haddr   = desc_q.haddr + 64'(chunk_q);
                    desc_d.maddr   = desc_q.maddr + 32'(chunk_q);
                    desc_d.len     = rem_next;
                    state_d        = (rem_next != 32'd0) ? ST_CALC : ST_IDLE;
                end else if (pcie_req_stall) begin
                    // The core is back-pressuring, so keep presenting the last accepted (sof) beat.
                    trn_td         = hold_td_q;
                    trn_trem_n     = 8'h00;
                    trn_tsof_n     = 1'b0;
                    trn_tsrc_rdy_n = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, descriptor and ORT registers with synchronous active-low reset.
    always_ff @(posedge pcie_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            desc_q      <= '0;
            chunk_q     <= '0;
            len_dw_q    <= '0;
            hold_td_q   <= '0;
            ort_v_q     <= 1'b0;
            ort_tag_q   <= '0;
            ort_iface_q <= '0;
            ort_mem_q   <= '0;
            ort_addr_q  <= '0;
            ort_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            chunk_q     <= chunk_d;
            len_dw_q    <= len_dw_d;
            hold_td_q   <= hold_td_d;
            ort_v_q     <= ort_v_d;
            ort_tag_q   <= ort_tag_d;
            ort_iface_q <= ort_iface_d;
            ort_mem_q   <= ort_mem_d;
            ort_addr_q  <= ort_addr_d;
            ort_len_q   <= ort_len_d;
        end
    end

    assign ort_req_v     = ort_v_q;
    assign ort_req_tag   = ort_tag_q;
    assign ort_req_iface = ort_iface_q;
    assign ort_req_mem   = ort_mem_q;
    assign ort_req_addr  = ort_addr_q;
    assign ort_req_len   = ort_len_q;

`ifdef PCIE_RD_STATS_EN
    logic [31:0] stat_tlp_q, stat_tlp_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Count finished TLPs and the HDR1 cycles spent waiting for a free tag. Both counters wrap.
    always_comb begin
        stat_tlp_d   = stat_tlp_q + (pcie_req_done ? 32'd1 : 32'd0);
        stat_stall_d = stat_stall_q + ((state_q == ST_HDR1 && !tag_v) ? 32'd1 : 32'd0);
    end

    // Statistics registers.
    always_ff @(posedge pcie_clk) begin
        if (!rst_n) begin
            stat_tlp_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_tlp_q   <= stat_tlp_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_tlp_cnt   = stat_tlp_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_pcie_tx_rd_split.sv
// Directed bench for pcie_tx_rd_split. A table of per-TLP vectors covers the main
// splitting function. Hand-written sequences cover tag starvation, HDR2 stall and
// reset mid-TLP. The stats checks are compiled only when PCIE_RD_STATS_EN is defined.
module tb_pcie_tx_rd_split;

    logic        pcie_clk = 1'b0;
    logic        rst_n;
    logic [15:0] pcie_id;
    logic [2:0]  cfg_mrrs;
    logic        rd_desc_v;
    logic        rd_desc_ready;
    logic [63:0] rd_desc_haddr;
    logic [15:0] rd_desc_len;
    logic [1:0]  rd_desc_iface;
    logic [3:0]  rd_desc_mem;
    logic [18:0] rd_desc_maddr;
    logic        tag_v;
    logic [4:0]  tag;
    logic        tag_take;
    logic        pcie_req_v;
    logic        pcie_req_grant;
    logic        pcie_req_stall;
    logic        pcie_req_done;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        ort_req_v;
    logic [4:0]  ort_req_tag;
    logic [1:0]  ort_req_iface;
    logic [3:0]  ort_req_mem;
    logic [18:0] ort_req_addr;
    logic [10:0] ort_req_len;
`ifdef PCIE_RD_STATS_EN
    logic [31:0] stat_tlp_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 pcie_clk = ~pcie_clk;

    pcie_tx_rd_split #(.MAX_RD_BYTES(4096)) dut (
        .pcie_clk       (pcie_clk),
        .rst_n          (rst_n),
        .pcie_id        (pcie_id),
        .cfg_mrrs       (cfg_mrrs),
        .rd_desc_v      (rd_desc_v),
        .rd_desc_ready  (rd_desc_ready),
        .rd_desc_haddr  (rd_desc_haddr),
        .rd_desc_len    (rd_desc_len),
        .rd_desc_iface  (rd_desc_iface),
        .rd_desc_mem    (rd_desc_mem),
        .rd_desc_maddr  (rd_desc_maddr),
        .tag_v          (tag_v),
        .tag            (tag),
        .tag_take       (tag_take),
        .pcie_req_v     (pcie_req_v),
        .pcie_req_grant (pcie_req_grant),
        .pcie_req_stall (pcie_req_stall),
        .pcie_req_done  (pcie_req_done),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .ort_req_v      (ort_req_v),
        .ort_req_tag    (ort_req_tag),
        .ort_req_iface  (ort_req_iface),
        .ort_req_mem    (ort_req_mem),
        .ort_req_addr   (ort_req_addr),
        .ort_req_len    (ort_req_len)
`ifdef PCIE_RD_STATS_EN
        ,
        .stat_tlp_cnt   (stat_tlp_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    // Zero-length or misaligned descriptors are illegal stimulus.
    always @(posedge pcie_clk) begin
        if (rst_n && rd_desc_v && rd_desc_ready)
            assert (rd_desc_len != 16'd0 && rd_desc_len[1:0] == 2'b00 && rd_desc_haddr[1:0] == 2'b00)
            else $error("illegal read descriptor presented");
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_sof(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pcie_clk);
            if (!trn_tsrc_rdy_n && !trn_tsof_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL sof_timeout: no sof beat within 8 cycles");
        end
    endtask

    task automatic put_desc(input logic [63:0] ha, input logic [15:0] ln, input logic [18:0] ma,
                            input logic [1:0] ifc, input logic [3:0] mm);
        rd_desc_haddr = ha;
        rd_desc_len   = ln;
        rd_desc_maddr = ma;
        rd_desc_iface = ifc;
        rd_desc_mem   = mm;
        rd_desc_v     = 1'b1;
    endtask

    typedef struct {
        logic        new_desc;
        logic [63:0] haddr;
        logic [15:0] len;
        logic [2:0]  mrrs;
        logic [18:0] maddr;
        logic [1:0]  iface;
        logic [3:0]  mem;
        logic [4:0]  tag;
        logic [63:0] exp_sof;
        logic [63:0] exp_eof;
        logic [7:0]  exp_trem;
        logic [18:0] exp_addr;
        logic [10:0] exp_len;
        logic        last;
    } vec_t;

    vec_t vecs[7];
    bit   ok;

    initial begin
        // One record per expected TLP. Continuation records reuse the descriptor fields.
        vecs[0] = '{1'b1, 64'h0000_0000_0000_1000, 16'd64,   3'd0, 19'h00100, 2'd1, 4'd2,  5'd3,
                    64'h0000_0010_ABCD_03FF, 64'h0000_1000_0000_0000, 8'h0f, 19'h00100, 11'd16,   1'b1};
        vecs[1] = '{1'b1, 64'h0000_0001_0000_0F80, 16'd512, 3'd2, 19'h02000, 2'd2, 4'd5,  5'd4,
                    64'h2000_0020_ABCD_04FF, 64'h0000_0001_0000_0F80, 8'h00, 19'h02000, 11'd32,   1'b0};
        vecs[2] = '{1'b0, 64'h0000_0001_0000_0F80, 16'd512, 3'd2, 19'h02000, 2'd2, 4'd5,  5'd5,
                    64'h2000_0060_ABCD_05FF, 64'h0000_0001_0000_1000, 8'h00, 19'h02080, 11'd96,   1'b1};
        vecs[3] = '{1'b1, 64'h0000_0000_2000_0008, 16'd4,   3'd0, 19'h7FFFC, 2'd3, 4'd15, 5'd6,
                    64'h0000_0001_ABCD_060F, 64'h2000_0008_0000_0000, 8'h0f, 19'h7FFFC, 11'd1,    1'b1};
        vecs[4] = '{1'b1, 64'h0000_0000_0000_0000, 16'd4096, 3'd5, 19'h01000, 2'd0, 4'd1,  5'd9,
                    64'h0000_0000_ABCD_09FF, 64'h0000_0000_0000_0000, 8'h0f, 19'h01000, 11'd1024, 1'b1};
        vecs[5] = '{1'b1, 64'h0000_0000_0000_5000, 16'd4100, 3'd7, 19'h40000, 2'd2, 4'd7,  5'd10,
                    64'h0000_0000_ABCD_0AFF, 64'h0000_5000_0000_0000, 8'h0f, 19'h40000, 11'd1024, 1'b0};
        vecs[6] = '{1'b0, 64'h0000_0000_0000_5000, 16'd4100, 3'd7, 19'h40000, 2'd2, 4'd7,  5'd11,
                    64'h0000_0001_ABCD_0B0F, 64'h0000_6000_0000_0000, 8'h0f, 19'h41000, 11'd1,    1'b1};

        rst_n          = 1'b0;
        pcie_id        = 16'hABCD;
        cfg_mrrs       = 3'd0;
        rd_desc_v      = 1'b0;
        rd_desc_haddr  = '0;
        rd_desc_len    = '0;
        rd_desc_iface  = '0;
        rd_desc_mem    = '0;
        rd_desc_maddr  = '0;
        tag_v          = 1'b1;
        tag            = '0;
        pcie_req_grant = 1'b1;
        pcie_req_stall = 1'b0;

        // Reset state
        repeat (3) @(posedge pcie_clk);
        @(negedge pcie_clk);
        chk("rst_ready",   rd_desc_ready, 1);
        chk("rst_req_v",   pcie_req_v, 0);
        chk("rst_done",    pcie_req_done, 0);
        chk("rst_tagtake", tag_take, 0);
        chk("rst_ort_v",   ort_req_v, 0);
        chk("rst_rdy_n",   trn_tsrc_rdy_n, 1);
        chk("rst_trem",    trn_trem_n, 8'hff);
        chk("rst_td",      trn_td, 0);
        @(posedge pcie_clk); #1;
        rst_n = 1'b1;

        // Table-driven TLP vectors
        for (int i = 0; i < 7; i++) begin
            @(posedge pcie_clk); #1;
            tag      = vecs[i].tag;
            cfg_mrrs = vecs[i].mrrs;
            if (vecs[i].new_desc) begin
                put_desc(vecs[i].haddr, vecs[i].len, vecs[i].maddr, vecs[i].iface, vecs[i].mem);
                @(negedge pcie_clk);
                chk("desc_ready", rd_desc_ready, 1);
                @(posedge pcie_clk); #1;
                rd_desc_v = 1'b0;
            end
            wait_sof(ok);
            if (!ok) continue;
            chk("sof_td",      trn_td, vecs[i].exp_sof);
            chk("sof_trem",    trn_trem_n, 8'h00);
            chk("sof_eof_n",   trn_teof_n, 1);
            chk("sof_tagtake", tag_take, 1);
            chk("sof_req_v",   pcie_req_v, 1);
            chk("sof_done",    pcie_req_done, 0);
            @(negedge pcie_clk);
            chk("eof_eof_n",   trn_teof_n, 0);
            chk("eof_sof_n",   trn_tsof_n, 1);
            chk("eof_rdy_n",   trn_tsrc_rdy_n, 0);
            chk("eof_td",      trn_td, vecs[i].exp_eof);
            chk("eof_trem",    trn_trem_n, vecs[i].exp_trem);
            chk("eof_done",    pcie_req_done, 1);
            chk("ort_v",       ort_req_v, 1);
            chk("ort_tag",     ort_req_tag, vecs[i].tag);
            chk("ort_addr",    ort_req_addr, vecs[i].exp_addr);
            chk("ort_len",     ort_req_len, vecs[i].exp_len);
            chk("ort_iface",   ort_req_iface, vecs[i].iface);
            chk("ort_mem",     ort_req_mem, vecs[i].mem);
            @(negedge pcie_clk);
            chk("post_ort_v",  ort_req_v, 0);
            chk("post_done",   pcie_req_done, 0);
            chk("post_ready",  rd_desc_ready, vecs[i].last);
        end

        // No free tag for 5 cycles in HDR1
        @(posedge pcie_clk); #1;
        cfg_mrrs = 3'd0;
        tag      = 5'd13;
        tag_v    = 1'b0;
        put_desc(64'h1000, 16'd64, 19'h0, 2'd0, 4'd0);
        @(posedge pcie_clk); #1;
        rd_desc_v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge pcie_clk);
            @(negedge pcie_clk);
            chk("notag_req_v",   pcie_req_v, 0);
            chk("notag_rdy_n",   trn_tsrc_rdy_n, 1);
            chk("notag_tagtake", tag_take, 0);
        end
        @(posedge pcie_clk); #1;
        tag_v = 1'b1;
        @(negedge pcie_clk);
        chk("notag_sof_td", trn_td, 64'h0000_0010_ABCD_0DFF);
        chk("notag_sof_n",  trn_tsof_n, 0);
        @(negedge pcie_clk);
        chk("notag_done",   pcie_req_done, 1);

        // Core stall for 3 cycles in HDR2
        @(posedge pcie_clk); #1;
        tag = 5'd12;
        put_desc(64'h1000, 16'd64, 19'h0, 2'd0, 4'd0);
        @(posedge pcie_clk); #1;
        rd_desc_v = 1'b0;
        wait_sof(ok);
        chk("stall_sof_td", trn_td, 64'h0000_0010_ABCD_0CFF);
        @(posedge pcie_clk); #1;
        pcie_req_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pcie_clk);
            chk("stall_hold_td",  trn_td, 64'h0000_0010_ABCD_0CFF);
            chk("stall_hold_rdy", trn_tsrc_rdy_n, 0);
            chk("stall_hold_sof", trn_tsof_n, 0);
            chk("stall_done",     pcie_req_done, 0);
            @(posedge pcie_clk); #1;
        end
        pcie_req_stall = 1'b0;
        @(negedge pcie_clk);
        chk("stall_eof_td", trn_td, 64'h0000_1000_0000_0000);
        chk("stall_eof_n",  trn_teof_n, 0);
        chk("stall_done1",  pcie_req_done, 1);
        @(negedge pcie_clk);
        chk("stall_done0",  pcie_req_done, 0);
        chk("stall_ready",  rd_desc_ready, 1);

`ifdef PCIE_RD_STATS_EN
        chk("stat_stall", stat_stall_cnt, 32'd5);
        chk("stat_tlp",   stat_tlp_cnt, 32'd9);
`endif

        // Reset asserted while the TLP is in HDR2
        @(posedge pcie_clk); #1;
        tag = 5'd14;
        put_desc(64'h0000_0001_0000_2000, 16'd256, 19'h100, 2'd1, 4'd3);
        @(posedge pcie_clk); #1;
        rd_desc_v = 1'b0;
        wait_sof(ok);
        @(posedge pcie_clk); #1;
        pcie_req_stall = 1'b1;
        @(negedge pcie_clk);
        @(posedge pcie_clk); #1;
        rst_n = 1'b0;
        @(posedge pcie_clk); #1;
        rst_n          = 1'b1;
        pcie_req_stall = 1'b0;
        @(negedge pcie_clk);
        chk("mrst_ready", rd_desc_ready, 1);
        chk("mrst_done",  pcie_req_done, 0);
        chk("mrst_req_v", pcie_req_v, 0);
        chk("mrst_rdy_n", trn_tsrc_rdy_n, 1);
        chk("mrst_sof_n", trn_tsof_n, 1);
        chk("mrst_eof_n", trn_teof_n, 1);
        chk("mrst_trem",  trn_trem_n, 8'hff);
        chk("mrst_td",    trn_td, 0);
        chk("mrst_ort_v", ort_req_v, 0);
`ifdef PCIE_RD_STATS_EN
        chk("mrst_stat_tlp",   stat_tlp_cnt, 0);
        chk("mrst_stat_stall", stat_stall_cnt, 0);
`endif
        @(negedge pcie_clk);
        chk("mrst_done_after", pcie_req_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
